// File: rtl/multi_edge_detector.sv
// multi_edge_detector
//   Per-channel synchroniser, optional debounce filter, registered edge
//   pulses, mode-gated events, sticky pending flags and saturating counters.
//   Build option: define MULTI_EDGE_DEBOUNCE_EN to add the FILT_LEN debounce
//   filter. When it is undefined, level is the synchroniser output and
//   FILT_LEN is ignored.
module multi_edge_detector #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       sig_in,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       level,
  output logic [N_CH-1:0]       rise,
  output logic [N_CH-1:0]       fall,
  output logic [N_CH-1:0]       evt,
  output logic [N_CH-1:0]       pending,
  output logic [N_CH*CNT_W-1:0] count,
  output logic                  irq
);

  // Reject illegal parameter sets at elaboration time.
  if (N_CH < 1 || SYNC_STAGES < 2 || FILT_LEN < 1 || CNT_W < 1) begin : g_param_check
    $error("multi_edge_detector: illegal parameter value");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   lvl;
    logic                   level_d_q;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   evt_q, evt_d;
    logic                   pend_q, pend_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Synchroniser chain; the last stage is the channel's clean sample.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DEBOUNCE_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic [FW-1:0] filt_cnt_q;
    logic          level_q;

    // Accept a new level only after it has differed for FILT_LEN edges.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_cnt_q <= '0;
        level_q    <= 1'b0;
      end else if (s != level_q) begin
        if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
          level_q    <= s;
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + 1'b1;
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end

    assign lvl = level_q;
`else
    assign lvl = s;
`endif

    // Next-state for pulses, sticky flag and counter; a new event beats clr.
    always_comb begin
      rise_d = lvl & ~level_d_q;
      fall_d = ~lvl & level_d_q;
      evt_d  = (rise_d & mode[2*i]) | (fall_d & mode[2*i+1]);
      pend_d = evt_d | (pend_q & ~clr[i]);
      cnt_d  = cnt_q;
      if (evt_d) begin
        if (clr[i])      cnt_d = CNT_W'(1);
        else if (&cnt_q) cnt_d = cnt_q;
        else             cnt_d = cnt_q + 1'b1;
      end else if (clr[i]) begin
        cnt_d = '0;
      end
    end

    // Register edge stage, pending flag and event counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_d_q <= 1'b0;
        rise_q    <= 1'b0;
        fall_q    <= 1'b0;
        evt_q     <= 1'b0;
        pend_q    <= 1'b0;
        cnt_q     <= '0;
      end else begin
        level_d_q <= lvl;
        rise_q    <= rise_d;
        fall_q    <= fall_d;
        evt_q     <= evt_d;
        pend_q    <= pend_d;
        cnt_q     <= cnt_d;
      end
    end

    assign level[i]                = lvl;
    assign rise[i]                 = rise_q;
    assign fall[i]                 = fall_q;
    assign evt[i]                  = evt_q;
    assign pending[i]              = pend_q;
    assign count[CNT_W*i +: CNT_W] = cnt_q;
  end

  assign irq = |pending;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Testbench for multi_edge_detector: directed phases plus randomized traffic
// checked against a history-based reference model.
module tb_multi_edge_detector;
  localparam int N  = 8;
  localparam int SS = 2;
  localparam int FL = 4;
  localparam int CW = 2;
`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam int LAT  = SS + (DB ? FL : 0);
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      sig_in = '0;
  logic [2*N-1:0]    mode = '0;
  logic [N-1:0]      clr = '0;
  logic [N-1:0]      level, rise, fall, evt, pending;
  logic [N*CW-1:0]   count;
  logic              irq;

  int errs = 0;
  int checks = 0;

  multi_edge_detector #(.N_CH(N), .SYNC_STAGES(SS), .FILT_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .mode(mode), .clr(clr),
    .level(level), .rise(rise), .fall(fall), .evt(evt), .pending(pending),
    .count(count), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: sample history, filtered level, previous level, outputs.
  logic [N-1:0] hq[$];
  logic [N-1:0] m_s, m_lev, m_levd, m_rise, m_fall, m_evt, m_pend;
  int           m_cnt[N];
  int           m_run[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    for (int k = 0; k < SS - 1; k++) hq.push_back('0);
    m_s = '0; m_lev = '0; m_levd = '0;
    m_rise = '0; m_fall = '0; m_evt = '0; m_pend = '0;
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_run[i] = 0; end
  endtask

  function automatic logic [N-1:0] m_level();
    return DB ? m_lev : m_s;
  endfunction

  // Apply one clock edge to the model using pre-edge values.
  task automatic model_edge();
    logic [N-1:0] os, ol;
    os = m_s;
    ol = m_level();
    for (int i = 0; i < N; i++) begin
      m_rise[i] = ol[i] & ~m_levd[i];
      m_fall[i] = ~ol[i] & m_levd[i];
      m_evt[i]  = (m_rise[i] & mode[2*i]) | (m_fall[i] & mode[2*i+1]);
      m_pend[i] = m_evt[i] | (m_pend[i] & ~clr[i]);
      if (m_evt[i])    m_cnt[i] = clr[i] ? 1 : ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX);
      else if (clr[i]) m_cnt[i] = 0;
      if (os[i] != m_lev[i]) begin
        m_run[i]++;
        if (m_run[i] == FL) begin m_lev[i] = os[i]; m_run[i] = 0; end
      end else begin
        m_run[i] = 0;
      end
    end
    m_levd = ol;
    hq.push_back(sig_in);
    while (hq.size() > SS) void'(hq.pop_front());
    m_s = hq[0];
  endtask

  task automatic check_all(input string tag);
    logic [N*CW-1:0] ec;
    for (int i = 0; i < N; i++) ec[i*CW +: CW] = m_cnt[i][CW-1:0];
    chk({tag, ".level"},   64'(level),   64'(m_level()));
    chk({tag, ".rise"},    64'(rise),    64'(m_rise));
    chk({tag, ".fall"},    64'(fall),    64'(m_fall));
    chk({tag, ".evt"},     64'(evt),     64'(m_evt));
    chk({tag, ".pending"}, 64'(pending), 64'(m_pend));
    chk({tag, ".count"},   64'(count),   64'(ec));
    chk({tag, ".irq"},     64'(irq),     64'(|m_pend));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".z_level"},   64'(level),   64'd0);
    chk({tag, ".z_rise"},    64'(rise),    64'd0);
    chk({tag, ".z_fall"},    64'(fall),    64'd0);
    chk({tag, ".z_evt"},     64'(evt),     64'd0);
    chk({tag, ".z_pending"}, 64'(pending), 64'd0);
    chk({tag, ".z_count"},   64'(count),   64'd0);
    chk({tag, ".z_irq"},     64'(irq),     64'd0);
  endtask

  int seq[$];
  bit seen;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_zero("reset");

    // ch0 rising edge latency.
    sig_in[0] = 1'b1;
    for (int n = 1; n <= LAT + 1; n++) begin
      step("lat");
      chk("lat_rise0",  64'(rise[0]),  64'(n == LAT + 1));
      chk("lat_level0", 64'(level[0]), 64'(n >= LAT));
      chk("lat_fall0",  64'(fall[0]),  64'd0);
    end
    sig_in[0] = 1'b0;
    repeat (LAT + 3) step("lat_settle");

`ifdef MULTI_EDGE_DEBOUNCE_EN
    // Short excursion must be swallowed; a long one must pass.
    seen = 1'b0;
    sig_in[1] = 1'b1;
    repeat (3) begin step("glitch"); seen |= rise[1] | level[1]; end
    sig_in[1] = 1'b0;
    repeat (LAT + 4) begin step("glitch"); seen |= rise[1] | level[1]; end
    chk("glitch_suppressed", 64'(seen), 64'd0);
    sig_in[1] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step("pulse6");
      chk("pulse6_rise1", 64'(rise[1]), 64'(n == LAT + 1));
    end
    sig_in[1] = 1'b0;
    for (int n = 1; n <= LAT + 2; n++) begin
      step("pulse6_rel");
      chk("pulse6_fall1", 64'(fall[1]), 64'(n == LAT + 1));
    end
`endif

    // Mode filtering on ch2 for each mode with one full toggle.
    for (int md = 1; md <= 4; md++) begin
      mode[5:4] = 2'(md & 3);
      clr[2] = 1'b1; step("mode_clr"); clr[2] = 1'b0;
      sig_in[2] = 1'b1; repeat (LAT + 3) step("mode_hi");
      sig_in[2] = 1'b0; repeat (LAT + 3) step("mode_lo");
      chk("mode_count2", 64'(count[5:4]), 64'((md == 3) ? 2 : ((md == 4) ? 0 : 1)));
    end

    // Saturation on ch4 with CNT_W=2.
    mode[9:8] = 2'b01;
    clr[4] = 1'b1; step("sat_clr"); clr[4] = 1'b0;
    seq.delete();
    repeat (5) begin
      sig_in[4] = 1'b1;
      repeat (LAT + 3) begin step("sat"); if (evt[4]) seq.push_back(int'(count[9:8])); end
      sig_in[4] = 1'b0;
      repeat (LAT + 3) begin step("sat"); if (evt[4]) seq.push_back(int'(count[9:8])); end
    end
    chk("sat_nevents", 64'(seq.size()), 64'd5);
    for (int k = 0; k < seq.size() && k < 5; k++)
      chk("sat_seq", 64'(seq[k]), 64'((k < 3) ? k + 1 : 3));

    // Randomized traffic against the model.
    for (int c = 0; c < 500; c++) begin
      if (c % 40 == 0) mode = 16'($urandom);
      clr = 8'($urandom & $urandom & $urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) sig_in[i] = ~sig_in[i];
      step("rand");
    end

    // Async reset mid-debounce with events pending on all channels.
    clr = '0; mode = '1;
    sig_in = '0; repeat (LAT + 4) step("pre_rst");
    sig_in = '1; repeat (LAT + 4) step("pre_rst");
    chk("pre_rst_pending", 64'(pending), 64'({N{1'b1}}));
    sig_in = '0; repeat (2) step("pre_rst");
    sig_in = '1;
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 1; n <= LAT + 1; n++) begin
      step("post_rst");
      chk("post_rst_rise", 64'(rise), (n == LAT + 1) ? 64'({N{1'b1}}) : 64'd0);
    end
    repeat (4) step("tail");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

- Parametrised, multi-channel edge detector.
- Each channel synchronises an asynchronous input and optionally debounces it.
- Each channel reports rising and falling edges as single-cycle pulses, filters them into events through a per-channel mode, and accumulates events into a sticky pending flag and a saturating counter.
- Sits between raw GPIO/status pins and the interrupt/status register block.

## Interface
Parameters:
- N_CH, 8: number of independent channels (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- FILT_LEN, 4: consecutive cycles a synchronised change must persist before acceptance (≥1; used only with debounce compiled in)
- CNT_W, 8: event counter width per channel (≥1)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sig_in  in  N_CH  asynchronous input levels
- mode  in  2*N_CH  channel i uses bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- clr  in  N_CH  per-channel clear of pending and count (level-sampled each edge)
- level  out  N_CH  filtered level per channel
- rise  out  N_CH  one-cycle rising-edge pulse, mode-independent
- fall  out  N_CH  one-cycle falling-edge pulse, mode-independent
- evt  out  N_CH  one-cycle pulse: (rise & mode[2i]) | (fall & mode[2i+1])
- pending  out  N_CH  sticky event flag
- count  out  N_CH*CNT_W  channel i at [CNT_W*i +: CNT_W], saturating event count
- irq  out  1  OR of all pending bits

## Operation
Per channel, in order:
- **Synchroniser:** a chain of SYNC_STAGES flops. Its last stage is `s`.
- **Filter (debounce compiled in):**
  - A counter of width clog2(FILT_LEN+1) runs while `s` ≠ `level`; it clears to 0 whenever `s` = `level`.
  - On the FILT_LEN-th consecutive differing edge, `level` ← `s` and the counter clears.
  - Without debounce compiled in, `level` = `s` (combinational).
- **Edge stage:**
  - A registered `level_d` holds the previous `level`.
  - At each edge: `rise` ← `level & ~level_d`; `fall` ← `~level & level_d`; `evt` ← the mode-gated OR.
  - `rise`, `fall` and `evt` are registered outputs.
- **Pending:** set at the same edge at which `evt` is registered high; cleared by `clr`. Set and clear on the same edge → set wins.
- **Count:**
  - +1 at the same edge as `evt`; saturates at 2^CNT_W−1 with no wrap.
  - `clr` → 0.
  - `clr` together with a new event → 1.
- **Mode:**
  - Mode 00: `rise`/`fall` still pulse; `evt`, `pending` and `count` are unaffected.
  - A mode change takes effect for edge detections registered at the next clock edge.
- Channels are fully independent. Simultaneous events on all channels are all captured.

## Timing
- Reset (asynchronous, immediate): all synchroniser flops, filter counters, `level`, `level_d`, `rise`, `fall`, `evt`, `pending`, `count` → 0; `irq` → 0.
- Reset mid-operation discards in-flight pulses and partially debounced changes.
- Because reset value is 0, an input high at reset release is reported as a rising edge after the normal latency.
- Let E0 be the first clock edge sampling a new stable `sig_in` value:
  - **Bypass:** `s` and `level` change after E0+SYNC_STAGES−1. `rise`/`fall`/`evt` are high for exactly the one cycle after E0+SYNC_STAGES.
  - **Debounce:** `level` changes after E0+SYNC_STAGES−1+FILT_LEN. Pulses are high for the one cycle after E0+SYNC_STAGES+FILT_LEN.
- With debounce, a synchronised excursion shorter than FILT_LEN cycles produces no `level` change and no pulse.
- `pending` and `count` update in the same cycle `evt` is high. `irq` follows `pending` combinationally (no extra latency).
- Back-to-back alternating `level` changes on consecutive cycles give alternating `rise`/`fall` pulses, with no pulse merging.

## Configuration
- Macro MULTI_EDGE_DEBOUNCE_EN:
  - **Defined:** the per-channel FILT_LEN debounce filter is instantiated, with the latencies above.
  - **Undefined:** no filter logic; `level` is the synchroniser output and FILT_LEN is ignored.
- All other behaviour is identical in both builds.

## Test plan
- **Reset release with `sig_in`=0**, defaults, bypass build: all outputs 0. Drive ch0 0→1 before E0 → `rise[0]`=1 for exactly the cycle after E0+2, `fall`=0, `level[0]`=1 from after E0+1.
- **Debounce build, FILT_LEN=4:**
  - A 3-cycle high pulse on ch1 → no `level`/`rise` change.
  - A 6-cycle high pulse → `rise[1]` one cycle after E0+6, then `fall[1]` one cycle after release E0'+6.
- **Mode filtering:**
  - ch2 mode=01 with a full high/low toggle → `evt` once, `count`=1.
  - mode=10 → `evt` only on fall.
  - mode=11 → two events, `count`=2.
  - mode=00 → `rise`/`fall` pulse, `count` unchanged, `pending`=0.
- **Pending/irq:**
  - An event on ch3 → `pending[3]`=1, `irq`=1.
  - `clr[3]` alone → both 0 next cycle.
  - `clr[3]` on the same edge as a new event → `pending[3]`=1, `count`=1.
- **CNT_W=2 saturation:** 5 events on ch4 → `count` sequence 1,2,3,3,3.
- **Asynchronous `rst_n` mid-debounce with events pending on all channels:** all outputs 0 immediately, without waiting for a clock edge. With the input held high across reset, `rise` is reported again after full latency.
